// File: rtl/secure_vault_pkg.sv
// Package vault_pkg: shared types and counter widths for the secure_vault combination lock.
//   state_e    : lock FSM states (IDLE, ENTER, OPEN, LOCKOUT)
//   dir_e      : per-tick encoder rotation (none / clockwise / anticlockwise)
//   *CntW      : widths of the step, fail, settle and tick counters
package vault_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StEnter   = 2'd1,
    StOpen    = 2'd2,
    StLockout = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DirNone = 2'd0,
    DirCw   = 2'd1,
    DirAcw  = 2'd2
  } dir_e;

  localparam int unsigned StepW      = 3;
  localparam int unsigned FailCntW   = 4;
  localparam int unsigned SettleCntW = 4;
  localparam int unsigned TickCntW   = 16;

endpackage

// File: rtl/secure_vault_if.sv
// Interface secure_vault_if: groups the lock's strobe, encoder, programming and status signals.
//   master : drives tick/enc_pos/relock/prog_*; observes unlocked/locked_out/step/fail_cnt/err
//   slave  : the vault itself (mirror image of master)
interface secure_vault_if #(
  parameter int unsigned POS_W = 5
);
  logic             tick;
  logic [POS_W-1:0] enc_pos;
  logic             relock;
  logic             prog_valid;
  logic [2:0]       prog_idx;
  logic [POS_W-1:0] prog_data;
  logic             unlocked;
  logic             locked_out;
  logic [2:0]       step;
  logic [3:0]       fail_cnt;
  logic             err;

  modport master (
    output tick, enc_pos, relock, prog_valid, prog_idx, prog_data,
    input  unlocked, locked_out, step, fail_cnt, err
  );

  modport slave (
    input  tick, enc_pos, relock, prog_valid, prog_idx, prog_data,
    output unlocked, locked_out, step, fail_cnt, err
  );
endinterface

// File: rtl/secure_vault_rot_dir.sv
// Module rot_dir: classifies encoder motion between consecutive ticks.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_tick         : sample strobe; previous position is captured on every tick
//   i_pos          : current encoder position
//   o_dir          : rotation since the previous tick (DirNone until a first sample exists)
module rot_dir
  import vault_pkg::*;
#(
  parameter int unsigned POS_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic [POS_W-1:0] i_pos,
  output dir_e             o_dir
);

  logic [POS_W-1:0] r_prev_pos;
  logic             r_valid;
  logic [POS_W-1:0] w_delta;

  // Modular difference: the upper half of the position space means anticlockwise.
  assign w_delta = i_pos - r_prev_pos;

  always_comb begin
    o_dir = DirNone;
    if (r_valid && (w_delta != '0)) begin
      o_dir = w_delta[POS_W-1] ? DirAcw : DirCw;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev_pos <= '0;
      r_valid    <= 1'b0;
    end else if (i_tick) begin
      r_prev_pos <= i_pos;
      r_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/secure_vault.sv
// Module secure_vault: rotary-dial combination lock.
//   i_clock, i_n_reset : clock, asynchronous active-low reset
//   io_vault (slave)   : tick, enc_pos, relock, prog_valid/idx/data in;
//                        unlocked, locked_out, step, fail_cnt, err out (all registered)
// Optional feature: define VAULT_LOCKOUT_EN to enable the timed lockout after MAX_TRIES failures.
module secure_vault
  import vault_pkg::*;
#(
  parameter int unsigned POS_W                        = 5,
  parameter int unsigned SEQ_LEN                      = 3,
  parameter logic [SEQ_LEN*POS_W-1:0] DEFAULT_CODE    = {5'd5, 5'd20, 5'd10},
  parameter int unsigned SETTLE_TICKS                 = 2,
  parameter int unsigned MAX_TRIES                    = 3,
  parameter int unsigned LOCKOUT_TICKS                = 8,
  parameter int unsigned OPEN_TICKS                   = 16
) (
  input  logic          i_clock,
  input  logic          i_n_reset,
  secure_vault_if.slave io_vault
);

  state_e                r_state, w_state_nxt;
  logic [StepW-1:0]      r_step, w_step_nxt;
  logic [FailCntW-1:0]   r_fail_cnt, w_fail_cnt_nxt, w_fail_inc;
  logic [SettleCntW-1:0] r_settle, w_settle_nxt, w_settle_inc;
  logic [TickCntW-1:0]   r_tcnt, w_tcnt_nxt, w_tcnt_inc;
  logic                  r_moved, w_moved_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_unlocked;
  logic                  w_fail;
  logic                  w_prog_en;
  logic [POS_W-1:0]      r_code [SEQ_LEN];
  logic [POS_W-1:0]      w_digit;
  dir_e                  w_dir, w_want;

  rot_dir #(
    .POS_W (POS_W)
  ) u_rot_dir (
    .i_clk   (i_clock),
    .i_rst_n (i_n_reset),
    .i_tick  (io_vault.tick),
    .i_pos   (io_vault.enc_pos),
    .o_dir   (w_dir)
  );

  assign w_prog_en    = io_vault.prog_valid && (r_state == StOpen);
  assign w_settle_inc = r_settle + 4'd1;
  assign w_tcnt_inc   = r_tcnt + 16'd1;
  assign w_fail_inc   = (&r_fail_cnt) ? r_fail_cnt : r_fail_cnt + 4'd1;
  // Even digits are dialled clockwise, odd digits anticlockwise.
  assign w_want       = r_step[0] ? DirAcw : DirCw;

  always_comb begin
    w_digit = '0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (r_step == StepW'(k)) w_digit = r_code[k];
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_step_nxt     = r_step;
    w_fail_cnt_nxt = r_fail_cnt;
    w_settle_nxt   = r_settle;
    w_tcnt_nxt     = r_tcnt;
    w_moved_nxt    = r_moved;
    w_err_nxt      = 1'b0;
    w_fail         = 1'b0;
    if (io_vault.tick) begin
      case (r_state)
        StIdle: begin
          if (w_dir == DirCw) begin
            w_state_nxt  = StEnter;
            w_step_nxt   = '0;
            w_moved_nxt  = 1'b1;
            w_settle_nxt = '0;
          end
        end
        StEnter: begin
          if (w_dir != DirNone) begin
            if (w_dir != w_want) begin
              w_fail = 1'b1;
            end else begin
              w_moved_nxt  = 1'b1;
              w_settle_nxt = '0;
            end
          end else if (r_moved) begin
            // A stop only counts once the current digit has seen some motion.
            if (w_settle_inc == SettleCntW'(SETTLE_TICKS)) begin
              if (io_vault.enc_pos == w_digit) begin
                w_moved_nxt  = 1'b0;
                w_settle_nxt = '0;
                if (r_step == StepW'(SEQ_LEN - 1)) begin
                  w_state_nxt    = StOpen;
                  w_step_nxt     = '0;
                  w_fail_cnt_nxt = '0;
                  w_tcnt_nxt     = '0;
                end else begin
                  w_step_nxt = r_step + 3'd1;
                end
              end else begin
                w_fail = 1'b1;
              end
            end else begin
              w_settle_nxt = w_settle_inc;
            end
          end
        end
        StOpen: begin
          w_tcnt_nxt = w_tcnt_inc;
          if (io_vault.relock || (w_tcnt_inc == TickCntW'(OPEN_TICKS))) begin
            w_state_nxt = StIdle;
            w_tcnt_nxt  = '0;
          end
        end
`ifdef VAULT_LOCKOUT_EN
        StLockout: begin
          // Motion is ignored here; only the tick count matters.
          w_tcnt_nxt = w_tcnt_inc;
          if (w_tcnt_inc == TickCntW'(LOCKOUT_TICKS)) begin
            w_state_nxt    = StIdle;
            w_fail_cnt_nxt = '0;
            w_tcnt_nxt     = '0;
          end
        end
`endif
        default: w_state_nxt = StIdle;
      endcase
    end

    if (w_fail) begin
      w_err_nxt      = 1'b1;
      w_fail_cnt_nxt = w_fail_inc;
      w_step_nxt     = '0;
      w_moved_nxt    = 1'b0;
      w_settle_nxt   = '0;
      w_state_nxt    = StIdle;
`ifdef VAULT_LOCKOUT_EN
      if (w_fail_inc == FailCntW'(MAX_TRIES)) begin
        w_state_nxt = StLockout;
        w_tcnt_nxt  = '0;
      end
`endif
    end
  end

  always_ff @(posedge i_clock or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_state    <= StIdle;
      r_step     <= '0;
      r_fail_cnt <= '0;
      r_settle   <= '0;
      r_tcnt     <= '0;
      r_moved    <= 1'b0;
      r_err      <= 1'b0;
      r_unlocked <= 1'b0;
      for (int k = 0; k < SEQ_LEN; k++) begin
        r_code[k] <= DEFAULT_CODE[k*POS_W +: POS_W];
      end
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      r_fail_cnt <= w_fail_cnt_nxt;
      r_settle   <= w_settle_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_moved    <= w_moved_nxt;
      r_err      <= w_err_nxt;
      r_unlocked <= (w_state_nxt == StOpen);
      for (int k = 0; k < SEQ_LEN; k++) begin
        if (w_prog_en && (io_vault.prog_idx == 3'(k))) r_code[k] <= io_vault.prog_data;
      end
    end
  end

`ifdef VAULT_LOCKOUT_EN
  logic r_locked_out;

  always_ff @(posedge i_clock or negedge i_n_reset) begin
    if (!i_n_reset) r_locked_out <= 1'b0;
    else            r_locked_out <= (w_state_nxt == StLockout);
  end

  assign io_vault.locked_out = r_locked_out;
`else
  logic w_unused_cfg;
  assign w_unused_cfg        = ^{MAX_TRIES, LOCKOUT_TICKS};
  assign io_vault.locked_out = 1'b0;
`endif

  assign io_vault.unlocked = r_unlocked;
  assign io_vault.step     = r_step;
  assign io_vault.fail_cnt = r_fail_cnt;
  assign io_vault.err      = r_err;

endmodule

// File: tb/tb_secure_vault.sv
module tb_secure_vault;

  localparam int SEQ    = 3;
  localparam int SETTLE = 2;
  localparam int MAXT   = 3;
  localparam int LOCKT  = 8;
  localparam int OPENT  = 16;
  localparam bit LOCK_EN =
`ifdef VAULT_LOCKOUT_EN
    1'b1;
`else
    1'b0;
`endif

  localparam int M_IDLE = 0, M_ENTER = 1, M_OPEN = 2, M_LOCK = 3;
  localparam int D_NONE = 0, D_CW = 1, D_ACW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  secure_vault_if #(.POS_W(5)) vif ();

  secure_vault dut (
    .i_clock   (clk),
    .i_n_reset (rst_n),
    .io_vault  (vif)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural reference model
  bit         m_valid;
  logic [4:0] m_prev;
  int         m_mode, m_step, m_fail, m_still, m_open, m_lock;
  bit         m_moved, m_err;
  logic [4:0] m_code [SEQ];

  logic [4:0] cur_pos;
  logic       last_err;

  typedef struct {
    logic [4:0] pos;
    logic       rl;
    logic       u;
    logic [2:0] st;
    logic [3:0] fc;
    logic       e;
  } vec_t;
  vec_t tbl [17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic model_reset();
    m_valid = 0; m_prev = '0; m_mode = M_IDLE; m_step = 0; m_fail = 0;
    m_still = 0; m_open = 0; m_lock = 0; m_moved = 0; m_err = 0;
    m_code[0] = 5'd10; m_code[1] = 5'd20; m_code[2] = 5'd5;
  endtask

  task automatic model_tick(input logic [4:0] pos, input logic rl);
    int mv, want;
    logic [4:0] delta;
    bit fail;
    mv = D_NONE;
    fail = 0;
    if (m_valid) begin
      delta = pos - m_prev;
      if (delta != 0) mv = (delta < 16) ? D_CW : D_ACW;
    end
    m_prev  = pos;
    m_valid = 1;
    m_err   = 0;
    case (m_mode)
      M_IDLE: if (mv == D_CW) begin
        m_mode = M_ENTER; m_step = 0; m_moved = 1; m_still = 0;
      end
      M_ENTER: begin
        want = (m_step % 2 == 0) ? D_CW : D_ACW;
        if (mv != D_NONE && mv != want) fail = 1;
        else if (mv == want) begin
          m_moved = 1; m_still = 0;
        end else if (m_moved) begin
          m_still++;
          if (m_still == SETTLE) begin
            if (pos == m_code[m_step]) begin
              if (m_step == SEQ - 1) begin
                m_mode = M_OPEN; m_step = 0; m_fail = 0; m_open = 0;
              end else m_step++;
              m_moved = 0; m_still = 0;
            end else fail = 1;
          end
        end
      end
      M_OPEN: begin
        m_open++;
        if (rl || m_open == OPENT) m_mode = M_IDLE;
      end
      default: begin
        m_lock++;
        if (m_lock == LOCKT) begin
          m_mode = M_IDLE; m_fail = 0;
        end
      end
    endcase
    if (fail) begin
      m_err = 1;
      m_fail = (m_fail < 15) ? m_fail + 1 : 15;
      m_step = 0; m_moved = 0; m_still = 0; m_mode = M_IDLE;
      if (LOCK_EN && m_fail == MAXT) begin
        m_mode = M_LOCK; m_lock = 0;
      end
    end
  endtask

  function automatic logic [9:0] outs();
    return {vif.unlocked, vif.locked_out, vif.step, vif.fail_cnt, vif.err};
  endfunction

  task automatic check(input string nm);
    logic [9:0] got, exp;
    got = outs();
    exp = {m_mode == M_OPEN, m_mode == M_LOCK, 3'(m_step), 4'(m_fail), m_err};
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got u=%0d lo=%0d step=%0d fc=%0d err=%0d, expected u=%0d lo=%0d step=%0d fc=%0d err=%0d",
               nm, got[9], got[8], got[7:5], got[4:1], got[0],
               exp[9], exp[8], exp[7:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic expect_v(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic drive_tick(input logic [4:0] pos, input logic rl);
    @(negedge clk);
    vif.enc_pos = pos; vif.tick = 1'b1; vif.relock = rl;
    @(posedge clk);
    model_tick(pos, rl);
    @(negedge clk);
    vif.tick = 1'b0; vif.relock = 1'b0;
  endtask

  task automatic do_tick(input logic [4:0] pos, input logic rl, input string nm);
    drive_tick(pos, rl);
    last_err = vif.err;
    check(nm);
    if (m_err) begin
      @(posedge clk);
      m_err = 0;
      @(negedge clk);
      check({nm, "_errclr"});
    end
  endtask

  task automatic rot(input logic [4:0] tgt, input bit cw, input string nm);
    logic [4:0] diff, s;
    for (int g = 0; g < 8 && cur_pos != tgt; g++) begin
      diff = cw ? tgt - cur_pos : cur_pos - tgt;
      s = (diff > 5'd8) ? 5'd8 : diff;
      cur_pos = cw ? cur_pos + s : cur_pos - s;
      do_tick(cur_pos, 1'b0, nm);
    end
  endtask

  task automatic stop(input int n);
    repeat (n) do_tick(cur_pos, 1'b0, "stop");
  endtask

  task automatic enter3(input logic [4:0] c0, input logic [4:0] c1, input logic [4:0] c2);
    if (cur_pos == c0) begin
      cur_pos = cur_pos - 5'd3;
      do_tick(cur_pos, 1'b0, "pre_acw");
    end
    rot(c0, 1'b1, "d0"); stop(2);
    rot(c1, 1'b0, "d1"); stop(2);
    rot(c2, 1'b1, "d2"); stop(2);
  endtask

  task automatic fail_once();
    logic [4:0] tgt;
    tgt = cur_pos + 5'd5;
    if (tgt == 5'd10) tgt = tgt + 5'd1;
    rot(tgt, 1'b1, "wrong"); stop(2);
  endtask

  task automatic prog(input logic [2:0] idx, input logic [4:0] data);
    @(negedge clk);
    vif.prog_valid = 1'b1; vif.prog_idx = idx; vif.prog_data = data;
    @(posedge clk);
    if (m_mode == M_OPEN && idx < SEQ) m_code[idx] = data;
    @(negedge clk);
    vif.prog_valid = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check(nm);
    expect_v({nm, "_zero"}, int'(outs()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_tick(cur_pos, 1'b0, {nm, "_capture"});
  endtask

  initial begin
    rst_n = 1'b0;
    vif.tick = 0; vif.enc_pos = '0; vif.relock = 0;
    vif.prog_valid = 0; vif.prog_idx = '0; vif.prog_data = '0;
    cur_pos = '0;
    last_err = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state");
    expect_v("reset_zero", int'(outs()), 0);
    rst_n = 1'b1;

    // Default-code unlock, relock, then a wrong first digit
    tbl[0]  = '{5'd0,  1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
    tbl[1]  = '{5'd5,  1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
    tbl[2]  = '{5'd10, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
    tbl[3]  = '{5'd10, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
    tbl[4]  = '{5'd10, 1'b0, 1'b0, 3'd1, 4'd0, 1'b0};
    tbl[5]  = '{5'd0,  1'b0, 1'b0, 3'd1, 4'd0, 1'b0};
    tbl[6]  = '{5'd20, 1'b0, 1'b0, 3'd1, 4'd0, 1'b0};
    tbl[7]  = '{5'd20, 1'b0, 1'b0, 3'd1, 4'd0, 1'b0};
    tbl[8]  = '{5'd20, 1'b0, 1'b0, 3'd2, 4'd0, 1'b0};
    tbl[9]  = '{5'd30, 1'b0, 1'b0, 3'd2, 4'd0, 1'b0};
    tbl[10] = '{5'd5,  1'b0, 1'b0, 3'd2, 4'd0, 1'b0};
    tbl[11] = '{5'd5,  1'b0, 1'b0, 3'd2, 4'd0, 1'b0};
    tbl[12] = '{5'd5,  1'b0, 1'b1, 3'd0, 4'd0, 1'b0};
    tbl[13] = '{5'd5,  1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
    tbl[14] = '{5'd11, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
    tbl[15] = '{5'd11, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
    tbl[16] = '{5'd11, 1'b0, 1'b0, 3'd0, 4'd1, 1'b1};
    for (int i = 0; i < 17; i++) begin
      drive_tick(tbl[i].pos, tbl[i].rl);
      cur_pos = tbl[i].pos;
      n_vec++;
      if (outs() !== {tbl[i].u, 1'b0, tbl[i].st, tbl[i].fc, tbl[i].e}) begin
        n_miss++;
        $display("FAIL table[%0d]: got %b, expected %b", i, outs(),
                 {tbl[i].u, 1'b0, tbl[i].st, tbl[i].fc, tbl[i].e});
      end
    end
    @(posedge clk);
    m_err = 0;
    @(negedge clk);
    check("table_errclr");

    // Digit 1 dialled clockwise fails on that tick
    rot(5'd10, 1'b1, "d0"); stop(2);
    expect_v("dir_step1", int'(vif.step), 1);
    cur_pos = cur_pos + 5'd3;
    do_tick(cur_pos, 1'b0, "wrong_dir");
    expect_v("dir_err", int'(last_err), 1);
    expect_v("dir_fc", int'(vif.fail_cnt), 2);

    // Third failure: lockout (if enabled), then the correct code
    fail_once();
    expect_v("third_fc", int'(vif.fail_cnt), 3);
    expect_v("third_lo", int'(vif.locked_out), int'(LOCK_EN));
    enter3(5'd10, 5'd20, 5'd5);
    expect_v("code_while_locked", int'(vif.unlocked), int'(!LOCK_EN));
    do_tick(cur_pos, 1'b1, "relock");
    enter3(5'd10, 5'd20, 5'd5);
    expect_v("open_default", int'(vif.unlocked), 1);
    expect_v("open_fc", int'(vif.fail_cnt), 0);

    // Reprogram digit 1, out-of-range and closed-state writes ignored
    prog(3'd1, 5'd7);
    prog(3'd5, 5'd9);
    do_tick(cur_pos, 1'b1, "relock");
    prog(3'd0, 5'd3);
    enter3(5'd10, 5'd7, 5'd5);
    expect_v("open_new", int'(vif.unlocked), 1);
    stop(OPENT - 1);
    expect_v("open_before_timeout", int'(vif.unlocked), 1);
    stop(1);
    expect_v("open_timeout", int'(vif.unlocked), 0);

    do_reset("rst_after_prog");
    enter3(5'd10, 5'd7, 5'd5);
    expect_v("old_code_rejected", int'(vif.unlocked), 0);
    expect_v("old_code_fc", int'(vif.fail_cnt), 2);
    enter3(5'd10, 5'd20, 5'd5);
    expect_v("default_restored", int'(vif.unlocked), 1);
    do_tick(cur_pos, 1'b1, "relock");

    // Reset mid-digit-2 and mid-lockout
    rot(5'd10, 1'b1, "d0"); stop(2);
    rot(5'd20, 1'b0, "d1"); stop(2);
    cur_pos = cur_pos + 5'd4;
    do_tick(cur_pos, 1'b0, "d2_part");
    do_reset("rst_mid_digit");
    repeat (MAXT) fail_once();
    stop(3);
    do_reset("rst_mid_lockout");
    enter3(5'd10, 5'd20, 5'd5);
    expect_v("unlock_after_rst", int'(vif.unlocked), 1);

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      int r;
      logic rl;
      r  = $urandom_range(0, 99);
      rl = ($urandom_range(0, 19) == 0);
      if (r < 40)      cur_pos = cur_pos;
      else if (r < 75) cur_pos = cur_pos + 5'($urandom_range(1, 6));
      else if (r < 90) cur_pos = cur_pos - 5'($urandom_range(1, 6));
      else             cur_pos = 5'($urandom_range(0, 31));
      do_tick(cur_pos, rl, "rand");
      if (m_mode == M_OPEN && $urandom_range(0, 3) == 0)
        prog(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      if (it % 50 == 25) enter3(m_code[0], m_code[1], m_code[2]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/secure_vault.md
SECURE_VAULT -- requirements
Module: secure_vault

Interface
REQ-001 Parameter POS_W, 5, encoder position width; position space wraps modulo 2^POS_W.
REQ-002 Parameter SEQ_LEN, 3, number of combination digits (2..8).
REQ-003 Parameter DEFAULT_CODE, {5'd5,5'd20,5'd10}, packed SEQ_LEN*POS_W reset combination; digit k at bits [k*POS_W +: POS_W].
REQ-004 Parameter SETTLE_TICKS, 2, consecutive motionless ticks that define a "stop" (1..15).
REQ-005 Parameter MAX_TRIES, 3, failed attempts before lockout.
REQ-006 Parameter LOCKOUT_TICKS, 8, lockout duration in ticks.
REQ-007 Parameter OPEN_TICKS, 16, auto-relock timeout in ticks.
REQ-008 clock  in  1  single system clock; all state changes on its rising edge.
REQ-009 n_reset  in  1  asynchronous, active-low reset.
REQ-010 tick  in  1  single-cycle sample strobe; all lock activity advances only on cycles with tick=1.
REQ-011 enc_pos  in  POS_W  rotary encoder position.
REQ-012 relock  in  1  level, sampled on tick; forces OPEN to IDLE.
REQ-013 prog_valid / prog_idx / prog_data  in  1 / 3 / POS_W  combination write port.
REQ-014 unlocked  out  1  high in OPEN only.
REQ-015 locked_out  out  1  high in LOCKOUT only.
REQ-016 step  out  3  index of the digit being entered.
REQ-017 fail_cnt  out  4  failed attempts since last success.
REQ-018 err  out  1  one-cycle pulse on each failed attempt.

Function
REQ-019 Direction per tick: delta = enc_pos - prev_pos mod 2^POS_W; 0 = none, 1..2^(POS_W-1)-1 = CW, 2^(POS_W-1)..max = ACW; prev_pos updates every tick.
REQ-020 First tick after reset shall only capture prev_pos and report no motion (valid flag clear at reset).
REQ-021 States IDLE, ENTER, OPEN, LOCKOUT; IDLE to ENTER with step=0 on first CW motion tick.
REQ-022 Digit k requires CW when k even, ACW when k odd; motion in the opposite direction during ENTER shall fail the attempt on that tick.
REQ-023 A stop (SETTLE_TICKS consecutive no-motion ticks after at least one motion tick in the current digit) compares enc_pos to code[step]: match advances step, mismatch fails.
REQ-024 Match on step=SEQ_LEN-1 shall enter OPEN on that tick, clear fail_cnt and step.
REQ-025 Failure: err pulses, fail_cnt increments (saturating at 15), step clears, state goes IDLE.
REQ-026 OPEN exits to IDLE on tick with relock=1 or after OPEN_TICKS ticks, whichever first; relock wins on the same tick as timeout.
REQ-027 prog_valid accepted only in OPEN with prog_idx<SEQ_LEN; write lands next cycle, otherwise ignored; reset restores DEFAULT_CODE.
REQ-028 Outputs registered; unlocked/locked_out/step change one cycle after the deciding tick.

Reset
REQ-029 n_reset low shall immediately force IDLE, step=0, fail_cnt=0, err=0, unlocked=0, locked_out=0, counters 0, code=DEFAULT_CODE, prev valid clear, including mid-entry or mid-lockout.

Configuration
REQ-030 Macro VAULT_LOCKOUT_EN defined: failure making fail_cnt reach MAX_TRIES enters LOCKOUT for LOCKOUT_TICKS ticks ignoring motion, then IDLE with fail_cnt cleared.
REQ-031 Macro absent: LOCKOUT unreachable, locked_out tied 0, fail_cnt still counts and saturates.

Structure
REQ-032 Package vault_pkg holds state enum, direction typedef (NONE/CW/ACW) and counter width constants.
REQ-033 Sub-module rot_dir computes direction and prev_pos/valid per REQ-019/020.

Verification (POS_W=5, code 10,20,5, SETTLE=2, MAX_TRIES=3)
REQ-034 CW 0->10, stop 2 ticks, ACW 10->20 via wrap, stop, CW 20->5 via wrap, stop -> unlocked=1, fail_cnt=0.
REQ-035 CW to 11, stop -> err pulse, fail_cnt=1, step=0, IDLE.
REQ-036 Digit 1 entered with CW motion -> err on that tick, step=0.
REQ-037 Three failures -> locked_out=1 for 8 ticks (with macro) or 0 (without); correct code ignored while locked.
REQ-038 In OPEN write idx1=7, relock, enter 10,7,5 -> unlocked; reset then 10,7,5 -> fail.
REQ-039 Assert n_reset mid-digit-2 and mid-lockout -> all outputs zero same cycle, next unlock needs DEFAULT_CODE.
